// File: rtl/id_operand_buffer_if.sv
// Decode-to-execute bundle between the decoder/regfile read and the EX stage.
// The slave view is the operand buffer. The master view is its environment.
interface id_operand_buffer_if #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3,
  parameter int CTRL_W  = 24
);
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [XLEN-1:0]         in_pc;
  logic [4:0]              in_rs1;
  logic [4:0]              in_rs2;
  logic [4:0]              in_rd;
  logic [XLEN-1:0]         in_imm;
  logic [CTRL_W-1:0]       in_ctrl;
  logic [XLEN-1:0]         in_rs1_data;
  logic [XLEN-1:0]         in_rs2_data;
  logic [NUM_FWD-1:0]      fwd_valid;
  logic [NUM_FWD*5-1:0]    fwd_rd;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         out_pc;
  logic [4:0]              out_rs1;
  logic [4:0]              out_rs2;
  logic [4:0]              out_rd;
  logic [XLEN-1:0]         out_imm;
  logic [CTRL_W-1:0]       out_ctrl;
  logic [XLEN-1:0]         out_rs1_data;
  logic [XLEN-1:0]         out_rs2_data;

  modport slave (
    input  flush, in_valid, in_pc, in_rs1, in_rs2, in_rd, in_imm, in_ctrl,
           in_rs1_data, in_rs2_data, fwd_valid, fwd_rd, fwd_data, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
           out_ctrl, out_rs1_data, out_rs2_data
  );

  modport master (
    output flush, in_valid, in_pc, in_rs1, in_rs2, in_rd, in_imm, in_ctrl,
           in_rs1_data, in_rs2_data, fwd_valid, fwd_rd, fwd_data, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
           out_ctrl, out_rs1_data, out_rs2_data
  );
endinterface

// File: rtl/id_operand_buffer.sv
// Two-entry skid buffer at the ID/EX boundary with prioritised operand forwarding.
// Held entries keep snooping the forwarding channels while they wait.
module id_operand_buffer #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3,
  parameter int CTRL_W  = 24
) (
  input  logic           clk,
  input  logic           rst,
  id_operand_buffer_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
  } entry_t;

  // Channel 0 is the youngest producer, so the lowest matching index wins.
  function automatic logic [XLEN-1:0] resolve(
    input logic [4:0]              rs,
    input logic [XLEN-1:0]         base,
    input logic [NUM_FWD-1:0]      fv,
    input logic [NUM_FWD*5-1:0]    frd,
    input logic [NUM_FWD*XLEN-1:0] fd
  );
    logic [XLEN-1:0] r;
    r = base;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fv[i] && (frd[5*i +: 5] == rs)) r = fd[XLEN*i +: XLEN];
    end
    if (rs == 5'd0) r = '0;
    return r;
  endfunction

  function automatic entry_t snoop(
    input entry_t                  e,
    input logic [NUM_FWD-1:0]      fv,
    input logic [NUM_FWD*5-1:0]    frd,
    input logic [NUM_FWD*XLEN-1:0] fd
  );
    entry_t r;
    r          = e;
    r.rs1_data = resolve(e.rs1, e.rs1_data, fv, frd, fd);
    r.rs2_data = resolve(e.rs2, e.rs2_data, fv, frd, fd);
    return r;
  endfunction

  entry_t head_q, head_d, skid_q, skid_d;
  logic   head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
  entry_t inc, head_snp, skid_snp;
  logic   accept, xfer;

  always_comb begin
    accept = bus.in_valid && !skid_vld_q && !bus.flush;
    xfer   = head_vld_q && bus.out_ready;

    inc.pc       = bus.in_pc;
    inc.rs1      = bus.in_rs1;
    inc.rs2      = bus.in_rs2;
    inc.rd       = bus.in_rd;
    inc.imm      = bus.in_imm;
    inc.ctrl     = bus.in_ctrl;
    inc.rs1_data = bus.in_rs1_data;
    inc.rs2_data = bus.in_rs2_data;
    inc          = snoop(inc, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);

    // Empty slots are left untouched so stale contents stay stable.
    head_snp = head_vld_q ? snoop(head_q, bus.fwd_valid, bus.fwd_rd, bus.fwd_data) : head_q;
    skid_snp = skid_vld_q ? snoop(skid_q, bus.fwd_valid, bus.fwd_rd, bus.fwd_data) : skid_q;

    head_d     = head_snp;
    skid_d     = skid_snp;
    head_vld_d = head_vld_q;
    skid_vld_d = skid_vld_q;

    if (bus.flush) begin
      head_d     = '0;
      skid_d     = '0;
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!head_vld_q || xfer) begin
      if (skid_vld_q) begin
        // in_ready is low whenever the skid is occupied, so no accept can coincide here.
        head_d     = skid_snp;
        head_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        head_d     = inc;
        head_vld_d = 1'b1;
      end else begin
        head_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = inc;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      skid_q     <= '0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign bus.in_ready     = !skid_vld_q;
  assign bus.out_valid    = head_vld_q;
  assign bus.out_pc       = head_q.pc;
  assign bus.out_rs1      = head_q.rs1;
  assign bus.out_rs2      = head_q.rs2;
  assign bus.out_rd       = head_q.rd;
  assign bus.out_imm      = head_q.imm;
  assign bus.out_ctrl     = head_q.ctrl;
  assign bus.out_rs1_data = head_q.rs1_data;
  assign bus.out_rs2_data = head_q.rs2_data;

endmodule

// File: tb/tb_id_operand_buffer.sv
// Scoreboard bench for id_operand_buffer: directed stimulus pushes expected
// entries, an independent monitor pops them as EX consumes the head.
module tb_id_operand_buffer;
  localparam int XLEN = 32;
  localparam int NF   = 3;
  localparam int CW   = 24;

  typedef logic [156:0] exp_t;  // {pc, rd, imm, ctrl, rs1_data, rs2_data}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_operand_buffer_if #(.XLEN(XLEN), .NUM_FWD(NF), .CTRL_W(CW)) bus ();
  id_operand_buffer #(.XLEN(XLEN), .NUM_FWD(NF), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   stalls = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic set_in(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [23:0] ctrl, input logic [31:0] r1d, input logic [31:0] r2d);
    bus.in_pc       = pc;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_rd       = pc[6:2];
    bus.in_imm      = ~pc;
    bus.in_ctrl     = ctrl;
    bus.in_rs1_data = r1d;
    bus.in_rs2_data = r2d;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted the entry.
  task automatic send(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [23:0] ctrl, input logic [31:0] r1d, input logic [31:0] r2d,
                      input logic [31:0] e1, input logic [31:0] e2);
    int   waits;
    logic rdy;
    waits = 0;
    rdy   = 1'b0;
    set_in(pc, rs1, rs2, ctrl, r1d, r2d);
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waits++;
      if (waits > 50) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: pc %0h not accepted after %0d cycles, required <= 50", pc, waits);
        break;
      end
    end
    if (rdy) sb.push_back({pc, pc[6:2], ~pc, ctrl, e1, e2});
    stalls += waits;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 160'(sb.size()), 160'd0);
  endtask

  // Monitor: every transfer out must match the oldest expected entry.
  initial begin
    exp_t got, e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.flush === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        got = {bus.out_pc, bus.out_rd, bus.out_imm, bus.out_ctrl, bus.out_rs1_data, bus.out_rs2_data};
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got pc %0h, required no transfer", bus.out_pc);
        end else begin
          e = sb.pop_front();
          chk("deliver", 160'(got), 160'(e));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.fwd_valid = '0; bus.fwd_rd = '0; bus.fwd_data = '0;
    set_in(32'h0, 5'd0, 5'd0, 24'h0, 32'h0, 32'h0);

    // Reset state
    #1;
    chk("rst_out_valid", 160'(bus.out_valid), 160'd0);
    chk("rst_in_ready", 160'(bus.in_ready), 160'd1);
    chk("rst_out_ctrl", 160'(bus.out_ctrl), 160'd0);
    chk("rst_out_pc", 160'(bus.out_pc), 160'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Reset mid-stream with both entries full
    send(32'h100, 5'd1, 5'd2, 24'h000101, 32'h11, 32'h22, 32'h11, 32'h22);
    send(32'h104, 5'd3, 5'd4, 24'h000102, 32'h33, 32'h44, 32'h33, 32'h44);
    chk("full_in_ready", 160'(bus.in_ready), 160'd0);
    chk("full_out_pc", 160'(bus.out_pc), 160'h100);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_out_valid", 160'(bus.out_valid), 160'd0);
    chk("midrst_in_ready", 160'(bus.in_ready), 160'd1);
    chk("midrst_out_ctrl", 160'(bus.out_ctrl), 160'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(32'h200, 5'd6, 5'd8, 24'h000201, 32'h66, 32'h88, 32'h66, 32'h88);
    chk("lat1_out_valid", 160'(bus.out_valid), 160'd1);
    chk("lat1_out_pc", 160'(bus.out_pc), 160'h200);
    drain();

    // Forwarding priority
    bus.fwd_data = {32'hCCCC0000, 32'hBBBB0000, 32'hAAAA0000};
    bus.fwd_rd   = {5'd5, 5'd5, 5'd5};
    bus.fwd_valid = 3'b110;
    send(32'h210, 5'd5, 5'd9, 24'h000301, 32'h55, 32'h99, 32'hBBBB0000, 32'h99);
    bus.fwd_valid = 3'b111;
    send(32'h214, 5'd5, 5'd10, 24'h000302, 32'h55, 32'hAA, 32'hAAAA0000, 32'hAA);
    bus.fwd_rd = {5'd5, 5'd5, 5'd0};
    send(32'h218, 5'd5, 5'd0, 24'h000303, 32'h55, 32'h1234, 32'hBBBB0000, 32'h0);
    bus.fwd_valid = '0; bus.fwd_rd = '0; bus.fwd_data = '0;
    drain();

    // Backpressure: I2 waits upstream until EX starts consuming
    bus.out_ready = 1'b0;
    send(32'h300, 5'd1, 5'd2, 24'h000401, 32'h1, 32'h2, 32'h1, 32'h2);
    send(32'h304, 5'd1, 5'd2, 24'h000402, 32'h3, 32'h4, 32'h3, 32'h4);
    chk("bp_in_ready", 160'(bus.in_ready), 160'd0);
    fork
      send(32'h308, 5'd1, 5'd2, 24'h000403, 32'h5, 32'h6, 32'h5, 32'h6);
      begin
        repeat (2) begin
          @(negedge clk);
          chk("bp_hold", 160'(bus.in_ready), 160'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("bp_stream", 160'(bus.out_valid), 160'd1);
        end
      end
    join
    @(posedge clk); #1;
    drain();

    // Stalled head and skid pick up a late producer result
    bus.out_ready = 1'b0;
    send(32'h400, 5'd3, 5'd7, 24'h000501, 32'h33, 32'h11, 32'h33, 32'hDEAD);
    chk("snoop_before", 160'(bus.out_rs2_data), 160'h11);
    send(32'h404, 5'd7, 5'd0, 24'h000502, 32'h55, 32'h66, 32'hDEAD, 32'h0);
    bus.fwd_rd    = {5'd7, 5'd0, 5'd0};
    bus.fwd_data  = {32'hDEAD, 32'h0, 32'h0};
    bus.fwd_valid = 3'b100;
    @(posedge clk); #1;
    bus.fwd_valid = '0; bus.fwd_rd = '0; bus.fwd_data = '0;
    chk("snoop_after", 160'(bus.out_rs2_data), 160'hDEAD);
    @(posedge clk); #1;
    chk("snoop_sticky", 160'(bus.out_rs2_data), 160'hDEAD);
    drain();

    // Flush collides with a full buffer, an incoming entry and a transfer
    bus.out_ready = 1'b0;
    send(32'h500, 5'd1, 5'd2, 24'h000601, 32'h1, 32'h2, 32'h1, 32'h2);
    send(32'h504, 5'd1, 5'd2, 24'h000602, 32'h1, 32'h2, 32'h1, 32'h2);
    set_in(32'h508, 5'd1, 5'd2, 24'h000603, 32'h1, 32'h2);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.flush = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_out_valid", 160'(bus.out_valid), 160'd0);
    chk("flush_out_ctrl", 160'(bus.out_ctrl), 160'd0);
    chk("flush_in_ready", 160'(bus.in_ready), 160'd1);
    chk("flush_out_pc", 160'(bus.out_pc), 160'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("flush_nodeliver", 160'(bus.out_valid), 160'd0);

    // Streaming: 16 back-to-back instructions
    bus.out_ready = 1'b1;
    stalls = 0;
    cnt = 0;
    fork
      for (int i = 0; i < 16; i++) begin
        logic [4:0] r2;
        r2 = (i % 4 == 0) ? 5'd0 : 5'(i);
        send(32'h1000 + 32'(4 * i), 5'(i + 1), r2, 24'h700000 | 24'(i),
             32'hA0000000 | 32'(i), 32'hBEEF0000 | 32'(i),
             32'hA0000000 | 32'(i), (r2 == 5'd0) ? 32'h0 : (32'hBEEF0000 | 32'(i)));
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.out_valid && w < 10) begin @(negedge clk); w++; end
        for (int k = 0; k < 16; k++) begin
          if (bus.out_valid) cnt++;
          if (k < 15) @(negedge clk);
        end
      end
    join
    @(posedge clk); #1;
    chk("stream_valid_cycles", 160'(cnt), 160'd16);
    chk("stream_in_ready_drops", 160'(stalls), 160'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
